// File: rtl/coherence_pkg.sv
// Shared MESI coherence types used by the L1 agent and the directory.
// Provides the state encoding, table entry layout and line-address helper.
package coherence_pkg;

    localparam int ADDR_W = 64;
    localparam int SRC_W  = 2;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] tag;
        mesi_e             state;
    } line_entry_t;

    function automatic logic [ADDR_W-1:0] line_addr(
        input logic [ADDR_W-1:0] addr,
        input int unsigned       off_bits
    );
        logic [ADDR_W-1:0] mask;
        mask = {ADDR_W{1'b1}} << off_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/l1_coh_line_table.sv
// Fully-associative tracked-line table with two CAM read ports.
// Ports: req_*/snp_* lookups, one write port, round-robin victim pointer.
import coherence_pkg::*;

module l1_coh_line_table #(
    parameter  int NUM_ENTRIES = 4,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] req_line,
    output logic              req_hit,
    output logic [IDX_W-1:0]  req_idx,
    output mesi_e             req_state,
    input  logic [ADDR_W-1:0] snp_line,
    output logic              snp_hit,
    output logic [IDX_W-1:0]  snp_idx,
    output mesi_e             snp_state,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_line,
    input  mesi_e             wr_state,
    input  logic              adv_ptr,
    output logic [IDX_W-1:0]  victim_idx,
    output logic              victim_valid,
    output logic [ADDR_W-1:0] victim_line
);

    line_entry_t tbl [NUM_ENTRIES];
    logic [IDX_W-1:0] ptr;

    // An entry is only valid while it holds a non-I state, so a
    // hit always implies a usable state.
    always_comb begin
        req_hit   = 1'b0;
        req_idx   = '0;
        req_state = MESI_I;
        snp_hit   = 1'b0;
        snp_idx   = '0;
        snp_state = MESI_I;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (tbl[i].valid && tbl[i].tag == req_line) begin
                req_hit   = 1'b1;
                req_idx   = IDX_W'(i);
                req_state = tbl[i].state;
            end
            if (tbl[i].valid && tbl[i].tag == snp_line) begin
                snp_hit   = 1'b1;
                snp_idx   = IDX_W'(i);
                snp_state = tbl[i].state;
            end
        end
    end

    assign victim_idx   = ptr;
    assign victim_valid = tbl[ptr].valid;
    assign victim_line  = tbl[ptr].tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl[i] <= '0;
            end
            ptr <= '0;
        end else begin
            if (wr_en) begin
                tbl[wr_idx].valid <= (wr_state != MESI_I);
                tbl[wr_idx].tag   <= wr_line;
                tbl[wr_idx].state <= wr_state;
            end
            if (adv_ptr) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/l1_coherence_agent.sv
// Per-core MESI agent: L1 requests to directory, directory snoops to L1.
// Ports: core_req/core_done, dir_req/dir_resp, inv/inv_ack, core_inv, err.
import coherence_pkg::*;

module l1_coherence_agent #(
    parameter int               LINE_BYTES   = 64,
    parameter int               NUM_ENTRIES  = 4,
    parameter logic [SRC_W-1:0] CORE_ID      = '0,
    parameter int               RESP_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req_valid_i,
    output logic              core_req_ready_o,
    input  logic [ADDR_W-1:0] core_req_addr_i,
    input  logic              core_req_write_i,
    output logic              core_done_o,
    output logic [1:0]        core_done_state_o,
    output logic              dir_req_valid_o,
    input  logic              dir_req_ready_i,
    output logic [ADDR_W-1:0] dir_req_addr_o,
    output logic              dir_req_write_o,
    output logic [SRC_W-1:0]  dir_req_src_o,
    input  logic              dir_resp_valid_i,
    input  logic [1:0]        dir_resp_state_i,
    input  logic              dir_resp_need_inval_i,
    input  logic              inv_valid_i,
    output logic              inv_ready_o,
    input  logic [ADDR_W-1:0] inv_addr_i,
    output logic              inv_ack_valid_o,
    input  logic              inv_ack_ready_i,
    output logic              inv_ack_dirty_o,
    output logic              core_inv_o,
    output logic [ADDR_W-1:0] core_inv_addr_o,
    output logic              err_o
);

    localparam int OFF_BITS = $clog2(LINE_BYTES);
    localparam int IDX_W    = $clog2(NUM_ENTRIES);
    localparam int CNT_W    = $clog2(RESP_TIMEOUT + 1);

    localparam logic [2:0] RQ_IDLE   = 3'd0;
    localparam logic [2:0] RQ_LOOKUP = 3'd1;
    localparam logic [2:0] RQ_DIR    = 3'd2;
    localparam logic [2:0] RQ_WAIT   = 3'd3;
    localparam logic [2:0] RQ_DONE   = 3'd4;

    localparam logic [1:0] SNP_IDLE   = 2'd0;
    localparam logic [1:0] SNP_LOOKUP = 2'd1;
    localparam logic [1:0] SNP_ACK    = 2'd2;

    logic [2:0]        rq_state;
    logic [1:0]        snp_st;
    logic [ADDR_W-1:0] req_line;
    logic              req_write;
    logic [CNT_W-1:0]  cnt;
    mesi_e             done_state;
    logic [ADDR_W-1:0] inv_line;
    logic              ack_dirty;
    logic              vic_pend;
    logic [ADDR_W-1:0] vic_pend_addr;

    logic              req_hit;
    logic [IDX_W-1:0]  req_idx;
    mesi_e             req_state;
    logic              snp_hit;
    logic [IDX_W-1:0]  snp_idx;
    mesi_e             snp_state;
    logic              tbl_wr_en;
    logic [IDX_W-1:0]  tbl_wr_idx;
    logic [ADDR_W-1:0] tbl_wr_line;
    mesi_e             tbl_wr_state;
    logic [IDX_W-1:0]  victim_idx;
    logic              victim_valid;
    logic [ADDR_W-1:0] victim_line;

    logic  unused_inputs;
    mesi_e resp_st;
    logic  resp_fire;
    logic  resp_ok;
    logic  install;
    logic  use_victim;
    logic  vic_pulse;
    logic  upgrade_em;
    logic  req_wr_en;
    logic  snp_act;
    logic  snp_wr;
    logic  cnt_last;

    assign unused_inputs = dir_resp_need_inval_i;

    assign resp_st    = mesi_e'(dir_resp_state_i);
    assign resp_fire  = (rq_state == RQ_WAIT) && dir_resp_valid_i;
    assign resp_ok    = (resp_st != MESI_I) &&
                        (!req_write || resp_st == MESI_M);
    assign install    = resp_fire && resp_ok;
    assign use_victim = install && !req_hit;
    assign vic_pulse  = use_victim && victim_valid;
    assign upgrade_em = (rq_state == RQ_LOOKUP) && req_write &&
                        req_hit && (req_state == MESI_E);
    assign req_wr_en  = upgrade_em || install;
    assign cnt_last   = (cnt == CNT_W'(RESP_TIMEOUT - 1));

    // A snoop lookup waits a cycle whenever the request side writes
    // the table, then re-looks-up against the updated contents.
    assign snp_act = (snp_st == SNP_LOOKUP) && !req_wr_en;
    assign snp_wr  = snp_act && snp_hit;

    always_comb begin
        tbl_wr_en    = req_wr_en || snp_wr;
        tbl_wr_idx   = snp_idx;
        tbl_wr_line  = inv_line;
        tbl_wr_state = MESI_I;
        if (upgrade_em) begin
            tbl_wr_idx   = req_idx;
            tbl_wr_line  = req_line;
            tbl_wr_state = MESI_M;
        end else if (install) begin
            tbl_wr_idx   = use_victim ? victim_idx : req_idx;
            tbl_wr_line  = req_line;
            tbl_wr_state = resp_st;
        end
    end

    l1_coh_line_table #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_line    (req_line),
        .req_hit     (req_hit),
        .req_idx     (req_idx),
        .req_state   (req_state),
        .snp_line    (inv_line),
        .snp_hit     (snp_hit),
        .snp_idx     (snp_idx),
        .snp_state   (snp_state),
        .wr_en       (tbl_wr_en),
        .wr_idx      (tbl_wr_idx),
        .wr_line     (tbl_wr_line),
        .wr_state    (tbl_wr_state),
        .adv_ptr     (use_victim),
        .victim_idx  (victim_idx),
        .victim_valid(victim_valid),
        .victim_line (victim_line)
    );

    // Ready is gated by rst_n so nothing is offered while in reset.
    assign core_req_ready_o = rst_n && (rq_state == RQ_IDLE) &&
                              (snp_st == SNP_IDLE);
    assign inv_ready_o = rst_n && (snp_st == SNP_IDLE) &&
                         (rq_state != RQ_LOOKUP) && !resp_fire;

    assign core_done_o       = (rq_state == RQ_DONE);
    assign core_done_state_o = done_state;
    assign dir_req_valid_o   = (rq_state == RQ_DIR);
    assign dir_req_addr_o    = dir_req_valid_o ? req_line : '0;
    assign dir_req_write_o   = dir_req_valid_o && req_write;
    assign dir_req_src_o     = dir_req_valid_o ? CORE_ID : '0;
    assign inv_ack_valid_o   = (snp_st == SNP_ACK);
    assign inv_ack_dirty_o   = inv_ack_valid_o && ack_dirty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rq_state   <= RQ_IDLE;
            req_line   <= '0;
            req_write  <= 1'b0;
            cnt        <= '0;
            done_state <= MESI_I;
            err_o      <= 1'b0;
        end else begin
            unique case (rq_state)
                RQ_IDLE: begin
                    if (core_req_valid_i && core_req_ready_o) begin
                        req_line  <= line_addr(core_req_addr_i, OFF_BITS);
                        req_write <= core_req_write_i;
                        rq_state  <= RQ_LOOKUP;
                    end
                end
                RQ_LOOKUP: begin
                    if (req_hit && (!req_write || req_state != MESI_S)) begin
                        done_state <= req_write ? MESI_M : req_state;
                        rq_state   <= RQ_DONE;
                    end else begin
                        rq_state <= RQ_DIR;
                    end
                end
                RQ_DIR: begin
                    if (dir_req_ready_i) begin
                        cnt      <= '0;
                        rq_state <= RQ_WAIT;
                    end
                end
                RQ_WAIT: begin
                    if (dir_resp_valid_i) begin
                        rq_state <= RQ_DONE;
                        if (resp_ok) begin
                            done_state <= resp_st;
                        end else begin
                            done_state <= MESI_I;
                            err_o      <= 1'b1;
                        end
                    end else if (cnt_last) begin
                        done_state <= MESI_I;
                        err_o      <= 1'b1;
                        rq_state   <= RQ_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RQ_DONE: rq_state <= RQ_IDLE;
                default: rq_state <= RQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snp_st    <= SNP_IDLE;
            inv_line  <= '0;
            ack_dirty <= 1'b0;
        end else begin
            unique case (snp_st)
                SNP_IDLE: begin
                    if (inv_valid_i && inv_ready_o) begin
                        inv_line <= line_addr(inv_addr_i, OFF_BITS);
                        snp_st   <= SNP_LOOKUP;
                    end
                end
                SNP_LOOKUP: begin
                    if (snp_act) begin
                        ack_dirty <= snp_hit && (snp_state == MESI_M);
                        snp_st    <= SNP_ACK;
                    end
                end
                SNP_ACK: begin
                    if (inv_ack_ready_i) begin
                        snp_st <= SNP_IDLE;
                    end
                end
                default: snp_st <= SNP_IDLE;
            endcase
        end
    end

    // Snoop drops win the core_inv slot; an eviction that collides
    // is parked and delivered on the next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_inv_o      <= 1'b0;
            core_inv_addr_o <= '0;
            vic_pend        <= 1'b0;
            vic_pend_addr   <= '0;
        end else begin
            core_inv_o <= 1'b0;
            if (snp_wr) begin
                core_inv_o      <= 1'b1;
                core_inv_addr_o <= inv_line;
                if (vic_pulse) begin
                    vic_pend      <= 1'b1;
                    vic_pend_addr <= victim_line;
                end
            end else if (vic_pend) begin
                core_inv_o      <= 1'b1;
                core_inv_addr_o <= vic_pend_addr;
                vic_pend        <= vic_pulse;
                vic_pend_addr   <= victim_line;
            end else if (vic_pulse) begin
                core_inv_o      <= 1'b1;
                core_inv_addr_o <= victim_line;
            end
        end
    end

endmodule
